echo_capture: RTL and testbench
===============================

# echo_capture

Front end of the height-sensor pipeline. Fires periodic trigger pulses at the ultrasonic ranger, synchronises the returning echo, and measures its high time in `clk` cycles. Publishes the result as the 32-bit `echo_width` consumed by the inch-conversion and height-latching stage, with a one-cycle `width_valid` strobe and a timeout flag.

## Interface
- `CLK_FREQ_HZ`, 12_000_000: `clk` frequency.
- `TRIG_US`, 10: trigger pulse length.
- `PERIOD_MS`, 60: measurement repeat period.
- `TIMEOUT_US`, 30_000: maximum time from trigger fall to echo fall.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  reset; synchronous, active-high.
- `echo`  in  1  raw echo from the sensor; asynchronous.
- `trig`  out  1  trigger to the sensor.
- `echo_width`  out  32  last measured width in `clk` cycles; held between updates.
- `width_valid`  out  1  one-cycle strobe when `echo_width` updates.
- `timeout`  out  1  high if the last measurement timed out; updated with `width_valid`.

## Operation
- Derived tick counts:
  - `TRIG_TICKS = CLK_FREQ_HZ/1_000_000*TRIG_US`
  - `PERIOD_TICKS = CLK_FREQ_HZ/1000*PERIOD_MS`
  - `TIMEOUT_TICKS = CLK_FREQ_HZ/1_000_000*TIMEOUT_US`
  - Elaboration-time check: `TRIG_TICKS+TIMEOUT_TICKS+4 < PERIOD_TICKS`.
- `echo` passes through a 2-flop synchroniser to give `echo_s`. Edges are detected against a third registered copy.
- Period counter:
  - Runs from 0 to `PERIOD_TICKS-1`, then wraps.
  - Reset to 0 in S_TRIG entry.
- States:
  - **S_TRIG:** `trig`=1 for exactly `TRIG_TICKS` cycles, then go to S_WAIT_RISE. The timeout counter clears to 0.
  - **S_WAIT_RISE:** wait for a rising edge of `echo_s`, then go to S_MEASURE with the width counter at 1. An echo already high on entry is not a rise.
  - **S_MEASURE:** the width counter increments each cycle `echo_s`=1. On the falling edge, publish `echo_width` = count and `timeout`=0, then go to S_HOLDOFF.
  - **S_HOLDOFF:** idle until the period counter reaches `PERIOD_TICKS-1`, then go to S_TRIG.
- Timeout:
  - The timeout counter runs in S_WAIT_RISE and S_MEASURE.
  - On reaching `TIMEOUT_TICKS`, publish `echo_width = TIMEOUT_TICKS` (saturated, reads as "far/ground") and `timeout`=1, then go to S_HOLDOFF.
  - If the echo falls in the same cycle the timeout is reached, the timeout wins.
- Width arithmetic: 32-bit unsigned. The counter saturates and never wraps.
- Reset, including mid-measurement:
  - All outputs go to 0 and all counters to 0, and the block enters S_TRIG.
  - The first trigger begins in the first cycle after `reset` drops.
  - An echo in flight is discarded.

## Timing
- Reset values: `trig`=0, `echo_width`=0, `width_valid`=0, `timeout`=0.
- `trig` rises in the first cycle after reset release. It stays high `TRIG_TICKS` cycles and repeats every `PERIOD_TICKS` cycles.
- Echo-to-output latency: `width_valid` asserts 3 cycles after the `echo` input falls (2 synchroniser cycles + 1 edge register). `echo_width` is valid in the same cycle as `width_valid`.
- Measured width equals the input high time in cycles, ±1 for asynchronous edges.
- Exactly one `width_valid` pulse per period. The pulse is never asserted while `trig`=1.

## Configuration
- `ECHO_MEDIAN3_EN` defined:
  - `echo_width` is the median of the last three raw results, timeouts included.
  - Until three results exist after reset, the raw value is passed.
  - `width_valid`/`echo_width` are delayed 1 further cycle (latency 4).
  - `timeout` still reflects the current raw result.
- Not defined: raw width published directly (latency 3).

## Structure
- Package `echo_capture_pkg`:
  - the `state_t` enum (S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF);
  - tick-count helper functions;
  - the default `CLK_FREQ_HZ`, shared with the height-latch stage.
- Sub-module `echo_median3` (3-entry history, count-to-3, registered median). Instantiated only under `ECHO_MEDIAN3_EN`.

## Test plan
All scenarios use bench parameters `CLK_FREQ_HZ`=1_000_000, `TRIG_US`=10, `PERIOD_MS`=1, `TIMEOUT_US`=500. Tick counts: TRIG=10, PERIOD=1000, TIMEOUT=500.
- **Basic measurement:** release reset; echo high 200 cycles starting 50 cycles after `trig` falls -> `trig` high cycles 1–10; `width_valid` once, 3 cycles after the echo falls; `echo_width`=200, `timeout`=0.
- **No echo:** `echo` held 0 -> `width_valid` at 500 cycles after `trig` fall with `echo_width`=500, `timeout`=1; the next trigger begins at cycle 1000 of the period.
- **Stuck-high echo:** `echo`=1 from before trigger -> no rise detected; timeout result 500/`timeout`=1.
- **Reset mid-measure:** assert `reset` 100 cycles into an echo -> all outputs 0 on the next edge; no `width_valid` for the aborted echo; a fresh trigger follows reset release.
- **Median (`ECHO_MEDIAN3_EN`):** raw widths 200, 200, 400, 200 -> outputs 200, 200, 200, 200, each at latency 4; without the macro, outputs 200, 200, 400, 200.
- **Period regularity:** echo 200 cycles every period for 5 periods -> `trig` rising edges exactly 1000 cycles apart; 5 `width_valid` pulses.

Source files
------------

// File: rtl/echo_capture_pkg.sv
// rtl/echo_capture_pkg.sv - shared state type, clock default and tick helpers for the ranger front end
package echo_capture_pkg;

  // Shared with the height-latch stage so both agree on the system clock.
  localparam int unsigned DEFAULT_CLK_FREQ_HZ = 12_000_000;

  typedef enum logic [1:0] {
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  function automatic logic [31:0] us_to_ticks(input int unsigned clk_hz, input int unsigned us);
    return clk_hz / 1_000_000 * us;
  endfunction

  function automatic logic [31:0] ms_to_ticks(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

  function automatic logic [31:0] median3(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    logic [31:0] m;
    if ((a <= b && b <= c) || (c <= b && b <= a)) begin
      m = b;
    end else if ((b <= a && a <= c) || (c <= a && a <= b)) begin
      m = a;
    end else begin
      m = c;
    end
    return m;
  endfunction

endpackage

// File: rtl/echo_capture_median3.sv
// rtl/echo_capture_median3.sv - median of the last three raw widths, one registered stage
module echo_median3
  import echo_capture_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_width_i,
  output logic        out_valid_o,
  output logic [31:0] out_width_o
);

  logic [31:0] hist0_q;
  logic [31:0] hist1_q;
  logic [1:0]  count_q;
  logic        valid_q;
  logic [31:0] width_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hist0_q <= '0;
      hist1_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      width_q <= '0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        hist0_q <= in_width_i;
        hist1_q <= hist0_q;
        if (count_q != 2'd3) begin
          count_q <= count_q + 2'd1;
        end
        // Two earlier results plus this one make a full window.
        if (count_q >= 2'd2) begin
          width_q <= median3(in_width_i, hist0_q, hist1_q);
        end else begin
          width_q <= in_width_i;
        end
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_width_o = width_q;

endmodule

// File: rtl/echo_capture.sv
// rtl/echo_capture.sv - ultrasonic trigger generator and echo high-time measurement
// Optional median-of-three output filter: define ECHO_MEDIAN3_EN.
module echo_capture
  import echo_capture_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned PERIOD_MS   = 60,
  parameter int unsigned TIMEOUT_US  = 30_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        echo,
  output logic        trig,
  output logic [31:0] echo_width,
  output logic        width_valid,
  output logic        timeout
);

  localparam logic [31:0] TRIG_TICKS    = us_to_ticks(CLK_FREQ_HZ, TRIG_US);
  localparam logic [31:0] PERIOD_TICKS  = ms_to_ticks(CLK_FREQ_HZ, PERIOD_MS);
  localparam logic [31:0] TIMEOUT_TICKS = us_to_ticks(CLK_FREQ_HZ, TIMEOUT_US);

  if (!(TRIG_TICKS + TIMEOUT_TICKS + 32'd4 < PERIOD_TICKS)) begin : g_cfg_check
    $error("echo_capture: trigger plus timeout does not fit in the period");
  end

  logic [2:0]  sync_q;
  logic        echo_s;
  logic        echo_rise;
  logic        echo_fall;

  state_t      state_q;
  logic        trig_q;
  logic [31:0] trig_cnt_q;
  logic [31:0] period_q;
  logic [31:0] period_d;
  logic [31:0] tmo_q;
  logic [31:0] tmo_d;
  logic        tmo_hit;
  logic [31:0] width_q;
  logic [31:0] width_d;

  logic        raw_valid_q;
  logic [31:0] raw_width_q;
  logic        raw_tmo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], echo};
    end
  end

  assign echo_s    = sync_q[1];
  assign echo_rise = sync_q[1] & ~sync_q[2];
  assign echo_fall = ~sync_q[1] & sync_q[2];

  always_comb begin
    period_d = (period_q == PERIOD_TICKS - 32'd1) ? '0 : period_q + 32'd1;
    // The first cycle out of reset is the launch cycle, not part of a period.
    if (state_q == S_TRIG && trig_cnt_q == '0) begin
      period_d = '0;
    end
    width_d = (width_q == '1) ? width_q : width_q + 32'd1;
    tmo_d   = tmo_q + 32'd1;
    tmo_hit = (tmo_d == TIMEOUT_TICKS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_TRIG;
      trig_q      <= 1'b0;
      trig_cnt_q  <= '0;
      period_q    <= '0;
      tmo_q       <= '0;
      width_q     <= '0;
      raw_valid_q <= 1'b0;
      raw_width_q <= '0;
      raw_tmo_q   <= 1'b0;
    end else begin
      period_q    <= period_d;
      raw_valid_q <= 1'b0;
      case (state_q)
        S_TRIG: begin
          tmo_q <= '0;
          if (trig_cnt_q == TRIG_TICKS) begin
            trig_q     <= 1'b0;
            trig_cnt_q <= '0;
            state_q    <= S_WAIT_RISE;
          end else begin
            trig_q     <= 1'b1;
            trig_cnt_q <= trig_cnt_q + 32'd1;
          end
        end
        S_WAIT_RISE: begin
          tmo_q <= tmo_d;
          if (tmo_hit) begin
            raw_valid_q <= 1'b1;
            raw_width_q <= TIMEOUT_TICKS;
            raw_tmo_q   <= 1'b1;
            state_q     <= S_HOLDOFF;
          end else if (echo_rise) begin
            width_q <= 32'd1;
            state_q <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          tmo_q <= tmo_d;
          // Timeout is checked first so it wins over a coincident fall.
          if (tmo_hit) begin
            raw_valid_q <= 1'b1;
            raw_width_q <= TIMEOUT_TICKS;
            raw_tmo_q   <= 1'b1;
            state_q     <= S_HOLDOFF;
          end else if (echo_fall) begin
            raw_valid_q <= 1'b1;
            raw_width_q <= width_q;
            raw_tmo_q   <= 1'b0;
            state_q     <= S_HOLDOFF;
          end else if (echo_s) begin
            width_q <= width_d;
          end
        end
        S_HOLDOFF: begin
          if (period_q == PERIOD_TICKS - 32'd1) begin
            trig_q     <= 1'b1;
            trig_cnt_q <= 32'd1;
            state_q    <= S_TRIG;
          end
        end
        default: begin
          state_q <= S_TRIG;
        end
      endcase
    end
  end

  assign trig = trig_q;

`ifdef ECHO_MEDIAN3_EN
  logic        med_valid;
  logic [31:0] med_width;
  logic        tmo_out_q;

  echo_median3 u_median3 (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (raw_valid_q),
    .in_width_i  (raw_width_q),
    .out_valid_o (med_valid),
    .out_width_o (med_width)
  );

  // Timeout tracks the raw result but moves with the delayed strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_out_q <= 1'b0;
    end else if (raw_valid_q) begin
      tmo_out_q <= raw_tmo_q;
    end
  end

  assign width_valid = med_valid;
  assign echo_width  = med_width;
  assign timeout     = tmo_out_q;
`else
  assign width_valid = raw_valid_q;
  assign echo_width  = raw_width_q;
  assign timeout     = raw_tmo_q;
`endif

endmodule

// File: tb/tb_echo_capture.sv
// tb/tb_echo_capture.sv - self-checking bench for echo_capture with a period-level result model
module tb_echo_capture;

  localparam int TRIG = 10;
  localparam int PER  = 1000;
  localparam int TMO  = 500;
`ifdef ECHO_MEDIAN3_EN
  localparam int LATX = 1;
  localparam bit MED  = 1'b1;
`else
  localparam int LATX = 0;
  localparam bit MED  = 1'b0;
`endif

  localparam int K_NONE  = 0;
  localparam int K_PULSE = 1;
  localparam int K_STUCK = 2;

  typedef struct packed {
    int kind;
    int c;
    int w;
  } cfg_t;

  typedef struct packed {
    int   ph;
    int   w;
    logic to;
  } res_t;

  logic        clk;
  logic        reset;
  logic        echo;
  logic        trig;
  logic [31:0] echo_width;
  logic        width_valid;
  logic        timeout;

  int nvec  = 0;
  int nfail = 0;
  int t     = 0;
  int seg   = 0;

  echo_capture #(
    .CLK_FREQ_HZ (1_000_000),
    .TRIG_US     (10),
    .PERIOD_MS   (1),
    .TIMEOUT_US  (500)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .echo        (echo),
    .trig        (trig),
    .echo_width  (echo_width),
    .width_valid (width_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-period echo stimulus; c is the phase where echo goes high, w its high time.
  function automatic cfg_t period_cfg(input int s, input int k);
    cfg_t r;
    r = '{kind: K_NONE, c: 0, w: 0};
    if (s == 0) begin
      case (k)
        0, 1, 3, 4: r = '{kind: K_PULSE, c: 60, w: 200};
        2:          r = '{kind: K_PULSE, c: 60, w: 400};
        6:          r = '{kind: K_STUCK, c: 0, w: 0};
        7:          r = '{kind: K_PULSE, c: 100, w: 150};
        default:    r = '{kind: K_NONE, c: 0, w: 0};
      endcase
    end else begin
      case (k)
        0:       r = '{kind: K_PULSE, c: 300, w: 206};
        1:       r = '{kind: K_PULSE, c: 300, w: 207};
        2:       r = '{kind: K_PULSE, c: 60, w: 200};
        default: r = '{kind: K_NONE, c: 0, w: 0};
      endcase
    end
    return r;
  endfunction

  function automatic logic echo_level(input int s, input int k, input int p);
    cfg_t cur;
    cfg_t nxt;
    cur = period_cfg(s, k);
    nxt = period_cfg(s, k + 1);
    return (cur.kind == K_PULSE && p >= cur.c && p < cur.c + cur.w) ||
           (cur.kind == K_STUCK && p < 700) ||
           (nxt.kind == K_STUCK && p >= 900);
  endfunction

  // Raw result of a period: pulse width 3 cycles after the echo falls, unless that
  // lands at or past 500 cycles after the trigger falls, in which case a timeout.
  function automatic res_t result_of(input int s, input int k);
    cfg_t cur;
    res_t r;
    int   f;
    cur = period_cfg(s, k);
    r = '{ph: TRIG + TMO, w: TMO, to: 1'b1};
    if (cur.kind == K_PULSE) begin
      f = cur.c + cur.w + 3;
      if (f < TRIG + TMO) r = '{ph: f, w: cur.w, to: 1'b0};
    end
    return r;
  endfunction

  function automatic int med3(input int a, input int b, input int c);
    int v[3];
    int tmp;
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2 - i; j++) begin
        if (v[j] > v[j+1]) begin
          tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
        end
      end
    end
    return v[1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL %s seg=%0d t=%0d: got %0d, expected %0d", name, seg, t, act, exp);
    end
  endtask

  int   hist[$];
  int   last_w;
  logic last_to;
  int   pend_w;
  logic pend_to;

  always @(posedge clk) begin : compare
    logic rst_s;
    int   k;
    int   p;
    res_t r;
    rst_s = reset;
    #1;
    if (rst_s) begin
      t = 0;
      hist.delete();
      last_w  = 0;
      last_to = 1'b0;
      chk("reset trig", {31'd0, trig}, 32'd0);
      chk("reset width_valid", {31'd0, width_valid}, 32'd0);
      chk("reset echo_width", echo_width, 32'd0);
      chk("reset timeout", {31'd0, timeout}, 32'd0);
    end else begin
      t++;
      k = (t - 1) / PER;
      p = (t - 1) % PER;
      r = result_of(seg, k);
      if (p == r.ph) begin
        hist.push_back(r.w);
        pend_to = r.to;
        if (MED && hist.size() >= 3)
          pend_w = med3(hist[hist.size()-1], hist[hist.size()-2], hist[hist.size()-3]);
        else
          pend_w = r.w;
      end
      if (p == r.ph + LATX) begin
        last_w  = pend_w;
        last_to = pend_to;
      end
      chk("trig", {31'd0, trig}, {31'd0, p < TRIG});
      chk("width_valid", {31'd0, width_valid}, {31'd0, p == r.ph + LATX});
      chk("echo_width", echo_width, last_w);
      chk("timeout", {31'd0, timeout}, {31'd0, last_to});

      if (seg == 0 && t == 1)    chk("lit trig first cycle", {31'd0, trig}, 32'd1);
      if (seg == 0 && t == 10)   chk("lit trig tenth cycle", {31'd0, trig}, 32'd1);
      if (seg == 0 && t == 11)   chk("lit trig falls", {31'd0, trig}, 32'd0);
      if (seg == 0 && t == 1000) chk("lit trig before repeat", {31'd0, trig}, 32'd0);
      if (seg == 0 && t == 1001) chk("lit trig repeat", {31'd0, trig}, 32'd1);
      if (seg == 0 && t == 264 + LATX) begin
        chk("lit basic valid", {31'd0, width_valid}, 32'd1);
        chk("lit basic width", echo_width, 32'd200);
        chk("lit basic timeout", {31'd0, timeout}, 32'd0);
      end
      if (seg == 0 && t == 2464 + LATX)
        chk("lit wide width", echo_width, MED ? 32'd200 : 32'd400);
      if (seg == 0 && t == 5511 + LATX) begin
        chk("lit no-echo valid", {31'd0, width_valid}, 32'd1);
        chk("lit no-echo timeout", {31'd0, timeout}, 32'd1);
      end
      if (seg == 0 && t == 6511 + LATX) begin
        chk("lit stuck width", echo_width, 32'd500);
        chk("lit stuck timeout", {31'd0, timeout}, 32'd1);
      end
      if (seg == 1 && t == 1)    chk("lit trig after reset", {31'd0, trig}, 32'd1);
      if (seg == 1 && t == 510 + LATX) begin
        chk("lit edge width", echo_width, MED ? 32'd206 : 32'd206);
        chk("lit edge valid", {31'd0, width_valid}, 32'd1);
      end
      if (seg == 1 && t == 1511 + LATX) begin
        chk("lit tie timeout", {31'd0, timeout}, 32'd1);
        chk("lit tie width", echo_width, 32'd500);
      end
    end
  end

  task automatic drive_echo();
    if (t >= 1) echo = echo_level(seg, (t - 1) / PER, (t - 1) % PER);
    else        echo = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    echo  = 1'b0;
    seg   = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do begin
      @(negedge clk);
      drive_echo();
    end while (t != 7 * PER + 200 + 1);
    // 100 cycles into the period-7 echo: abort it with reset.
    reset = 1'b1;
    echo  = 1'b0;
    seg   = 1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do begin
      @(negedge clk);
      drive_echo();
    end while (t != 3 * PER + 20);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
